snake_grid_map: RTL and testbench

//   Occupancy bitmap of the snake playfield; consumer of the snake body's head/tail stream.
//   - Each move sets the new head cell and clears the vacated tail cell. On a scoring move the tail cell is not cleared.
//   - Flags self-collision when the new head lands on an occupied cell.
//   - Gives the VGA renderer a registered per-cell occupancy lookup.

---
 rtl/snake_grid_map.sv | 180 ++++++++++++++++++
 tb/tb_snake_grid_map.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_grid_map.sv
// rtl/snake_grid_map.sv - occupancy bitmap of the snake playfield with move update and per-cell lookup
// Optional feature macro: SNAKE_GRID_CNT_EN adds the cell_count port and occupied-cell counter.
// Moves arrive as head/tail pairs: the tail cell is cleared first (skipped on a grow move),
// then the head cell is read for self-collision and set. The lookup port is an independent
// one-cycle registered read that never stalls the update path.

module snake_grid_map #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5,
  parameter int H_LOGIC_MAX   = 31,
  parameter int V_LOGIC_MAX   = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic                     upd_grow,
  input  logic [H_LOGIC_WIDTH-1:0] upd_headx,
  input  logic [V_LOGIC_WIDTH-1:0] upd_heady,
  input  logic [H_LOGIC_WIDTH-1:0] upd_tailx,
  input  logic [V_LOGIC_WIDTH-1:0] upd_taily,
  output logic                     upd_done,
  output logic                     hit_pulse,
  output logic                     hit,
  output logic                     init_done,
  input  logic                     qry_en,
  input  logic [H_LOGIC_WIDTH-1:0] qry_x,
  input  logic [V_LOGIC_WIDTH-1:0] qry_y,
`ifdef SNAKE_GRID_CNT_EN
  output logic [9:0]               cell_count,
`endif
  output logic                     qry_vld,
  output logic                     qry_occ
);

  // Row counter is one bit wider so it can step past the last row to mark the sweep end.
  localparam int CNT_W = V_LOGIC_WIDTH + 1;
  localparam logic [H_LOGIC_WIDTH-1:0] H_MAX  = H_LOGIC_WIDTH'(H_LOGIC_MAX);
  localparam logic [V_LOGIC_WIDTH-1:0] V_MAX  = V_LOGIC_WIDTH'(V_LOGIC_MAX);
  localparam logic [CNT_W-1:0]         V_LAST = CNT_W'(V_LOGIC_MAX);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_CLR_TAIL,
    S_SET_HEAD
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [H_LOGIC_MAX:0]     r_map [0:V_LOGIC_MAX];
  logic [H_LOGIC_WIDTH-1:0] r_headx;
  logic [V_LOGIC_WIDTH-1:0] r_heady;
  logic [H_LOGIC_WIDTH-1:0] r_tailx;
  logic [V_LOGIC_WIDTH-1:0] r_taily;
  logic                     r_upd_ready;
  logic                     r_upd_done;
  logic                     r_hit_pulse;
  logic                     r_hit;
  logic                     r_init_done;
  logic                     r_qry_vld;
  logic                     r_qry_occ;

  logic w_head_in;
  logic w_tail_in;
  logic w_qry_in;
  logic w_head_bit;

  // Out-of-range coordinates never touch the map; the row/column checks gate every access.
  assign w_head_in  = (r_headx <= H_MAX) && (r_heady <= V_MAX);
  assign w_tail_in  = (r_tailx <= H_MAX) && (r_taily <= V_MAX);
  assign w_qry_in   = (qry_x <= H_MAX) && (qry_y <= V_MAX);
  assign w_head_bit = w_head_in && r_map[r_heady][r_headx];

  assign upd_ready = r_upd_ready;
  assign upd_done  = r_upd_done;
  assign hit_pulse = r_hit_pulse;
  assign hit       = r_hit;
  assign init_done = r_init_done;
  assign qry_vld   = r_qry_vld;
  assign qry_occ   = r_qry_occ;

  // Update FSM: clear sweep, move acceptance, tail clear, head check-and-set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_headx     <= '0;
      r_heady     <= '0;
      r_tailx     <= '0;
      r_taily     <= '0;
      r_upd_ready <= 1'b0;
      r_upd_done  <= 1'b0;
      r_hit_pulse <= 1'b0;
      r_hit       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_upd_done  <= 1'b0;
      r_hit_pulse <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_cnt <= V_LAST) begin
            r_map[r_cnt[V_LOGIC_WIDTH-1:0]] <= '0;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_state     <= S_IDLE;
            r_upd_ready <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (upd_valid && r_upd_ready) begin
            r_headx     <= upd_headx;
            r_heady     <= upd_heady;
            r_tailx     <= upd_tailx;
            r_taily     <= upd_taily;
            r_upd_ready <= 1'b0;
            r_state     <= upd_grow ? S_SET_HEAD : S_CLR_TAIL;
          end
        end
        S_CLR_TAIL: begin
          if (w_tail_in) begin
            r_map[r_taily][r_tailx] <= 1'b0;
          end
          r_state <= S_SET_HEAD;
        end
        S_SET_HEAD: begin
          r_hit_pulse <= w_head_bit;
          r_hit       <= r_hit | w_head_bit;
          if (w_head_in) begin
            r_map[r_heady][r_headx] <= 1'b1;
          end
          r_upd_done  <= 1'b1;
          r_upd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  // Lookup: registered read of the map as it stood before this edge's writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qry_vld <= 1'b0;
      r_qry_occ <= 1'b0;
    end else begin
      r_qry_vld <= qry_en;
      r_qry_occ <= qry_en && w_qry_in && (r_state != S_INIT) && r_map[qry_y][qry_x];
    end
  end

`ifdef SNAKE_GRID_CNT_EN
  localparam logic [9:0] CELLS = 10'((H_LOGIC_MAX + 1) * (V_LOGIC_MAX + 1));

  logic       w_tail_bit;
  logic [9:0] r_cell_count;

  assign w_tail_bit = w_tail_in && r_map[r_taily][r_tailx];
  assign cell_count = r_cell_count;

  // Occupied-cell counter: moves only when a write actually flips a bit, saturating at both ends.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_INIT)) begin
      r_cell_count <= '0;
    end else if ((r_state == S_SET_HEAD) && w_head_in && !w_head_bit) begin
      if (r_cell_count != CELLS) begin
        r_cell_count <= r_cell_count + 10'd1;
      end
    end else if ((r_state == S_CLR_TAIL) && w_tail_bit) begin
      if (r_cell_count != 10'd0) begin
        r_cell_count <= r_cell_count - 10'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_snake_grid_map.sv
// tb/tb_snake_grid_map.sv - self-checking bench for snake_grid_map against a cell-array model
module tb_snake_grid_map;
  localparam int HW = 5;
  localparam int VW = 5;
  localparam int HM = 31;
  localparam int VM = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic          upd_grow = 1'b0;
  logic [HW-1:0] upd_headx = '0;
  logic [VW-1:0] upd_heady = '0;
  logic [HW-1:0] upd_tailx = '0;
  logic [VW-1:0] upd_taily = '0;
  logic          upd_done;
  logic          hit_pulse;
  logic          hit;
  logic          init_done;
  logic          qry_en = 1'b0;
  logic [HW-1:0] qry_x = '0;
  logic [VW-1:0] qry_y = '0;
  logic          qry_vld;
  logic          qry_occ;
`ifdef SNAKE_GRID_CNT_EN
  logic [9:0]    cell_count;
`endif

  always #5 clk = ~clk;

  snake_grid_map dut (
    .clk       (clk),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_grow  (upd_grow),
    .upd_headx (upd_headx),
    .upd_heady (upd_heady),
    .upd_tailx (upd_tailx),
    .upd_taily (upd_taily),
    .upd_done  (upd_done),
    .hit_pulse (hit_pulse),
    .hit       (hit),
    .init_done (init_done),
    .qry_en    (qry_en),
    .qry_x     (qry_x),
    .qry_y     (qry_y),
`ifdef SNAKE_GRID_CNT_EN
    .cell_count(cell_count),
`endif
    .qry_vld   (qry_vld),
    .qry_occ   (qry_occ)
  );

  int total = 0;
  int bad   = 0;

  bit mdl [0:VM][0:HM];
  int mdl_hit;

  typedef struct {
    bit g;
    int hx;
    int hy;
    int tx;
    int ty;
    int exp_hp;
    int exp_occ;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int in_rng(input int x, input int y);
    return (x >= 0 && x <= HM && y >= 0 && y <= VM) ? 1 : 0;
  endfunction

  function automatic int mdl_pop();
    int n = 0;
    for (int y = 0; y <= VM; y++)
      for (int x = 0; x <= HM; x++)
        n += int'(mdl[y][x]);
    return n;
  endfunction

  // Reference move: tail vacated first unless growing, then head checked and occupied.
  task automatic mdl_move(input bit g, input int hx, input int hy, input int tx, input int ty,
                          output int hp);
    if (!g && in_rng(tx, ty) == 1) mdl[ty][tx] = 1'b0;
    hp = 0;
    if (in_rng(hx, hy) == 1) begin
      hp = int'(mdl[hy][hx]);
      mdl[hy][hx] = 1'b1;
    end
    if (hp == 1) mdl_hit = 1;
  endtask

  task automatic mdl_clear();
    for (int y = 0; y <= VM; y++)
      for (int x = 0; x <= HM; x++)
        mdl[y][x] = 1'b0;
    mdl_hit = 0;
  endtask

  task automatic chk_count(input string nm);
`ifdef SNAKE_GRID_CNT_EN
    chk(nm, int'(cell_count), mdl_pop());
`else
    chk(nm, 0, 0 * mdl_pop());
`endif
  endtask

  // Reset from the current cycle; checks reset outputs, INIT lookups and sweep length.
  task automatic do_reset();
    int n;
    int nbad;
    rst = 1'b1;
    upd_valid = 1'b0;
    qry_en = 1'b1;
    qry_x = 5'd5;
    qry_y = 5'd5;
    tick();
    rst = 1'b0;
    chk("reset_outputs", int'({upd_ready, upd_done, hit_pulse, hit, init_done, qry_vld, qry_occ}), 0);
    n = 0;
    nbad = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
      if (qry_occ || upd_done) nbad++;
    end
    qry_en = 1'b0;
    chk("init_cycles", n, 25);
    chk("init_quiet", nbad, 0);
    chk("init_ready", int'(upd_ready), 1);
    mdl_clear();
    chk_count("init_count");
  endtask

  task automatic query(input int x, input int y, output int occ);
    qry_x = HW'(x);
    qry_y = VW'(y);
    qry_en = 1'b1;
    tick();
    qry_en = 1'b0;
    chk("qry_vld", int'(qry_vld), 1);
    occ = int'(qry_occ);
  endtask

  task automatic sweep(input string nm);
    int nbad = 0;
    for (int y = 0; y <= VM; y++) begin
      for (int x = 0; x <= HM; x++) begin
        qry_x = HW'(x);
        qry_y = VW'(y);
        qry_en = 1'b1;
        tick();
        if (qry_vld !== 1'b1 || qry_occ !== mdl[y][x]) nbad++;
      end
    end
    qry_en = 1'b0;
    chk(nm, nbad, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!upd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!upd_ready) chk("ready_timeout", 0, 1);
  endtask

  // One move through the handshake; returns DUT hit_pulse and model expectation.
  task automatic move(input bit g, input int hx, input int hy, input int tx, input int ty,
                      output int hp, output int exp_hp);
    int lat;
    wait_ready();
    upd_valid = 1'b1;
    upd_grow  = g;
    upd_headx = HW'(hx);
    upd_heady = VW'(hy);
    upd_tailx = HW'(tx);
    upd_taily = VW'(ty);
    tick();
    upd_valid = 1'b0;
    lat = 0;
    while (!upd_done && lat < 20) begin
      tick();
      lat++;
    end
    chk("upd_latency", lat, g ? 1 : 2);
    hp = int'(hit_pulse);
    mdl_move(g, hx, hy, tx, ty, exp_hp);
  endtask

  initial begin
    int hp;
    int ehp;
    int occ;
    int nbad;

    vt[0] = '{1'b1, 16, 11,  0,  0, 0, 1};
    vt[1] = '{1'b0, 17, 11, 16, 11, 0, 1};
    vt[2] = '{1'b1,  5,  5,  0,  0, 0, 1};
    vt[3] = '{1'b0,  5,  5,  9,  9, 1, 1};
    vt[4] = '{1'b0,  0, 24, 31, 23, 0, 0};
    vt[5] = '{1'b0, 17, 11, 17, 11, 0, 1};
    vt[6] = '{1'b1, 31, 23,  0,  0, 0, 1};
    vt[7] = '{1'b1, 31, 23,  0,  0, 1, 1};

    mdl_clear();
    do_reset();
    sweep("init_map");

    for (int i = 0; i < 8; i++) begin
      move(vt[i].g, vt[i].hx, vt[i].hy, vt[i].tx, vt[i].ty, hp, ehp);
      chk($sformatf("vec%0d_hit_pulse", i), hp, vt[i].exp_hp);
      query(vt[i].hx, vt[i].hy, occ);
      chk($sformatf("vec%0d_head_occ", i), occ, vt[i].exp_occ);
      chk_count($sformatf("vec%0d_count", i));
    end
    chk("hit_sticky", int'(hit), 1);

    query(3, 30, occ);
    chk("qry_oob_y30", occ, 0);
    query(0, 24, occ);
    chk("qry_oob_y24", occ, 0);

    nbad = 0;
    for (int i = 0; i < 80; i++) begin
      bit g;
      int hx, hy, tx, ty;
      g  = 1'($urandom_range(0, 1));
      hx = int'($urandom_range(0, 11));
      hy = int'($urandom_range(18, 26));
      tx = int'($urandom_range(0, 11));
      ty = int'($urandom_range(18, 26));
      move(g, hx, hy, tx, ty, hp, ehp);
      if (hp != ehp) begin
        nbad++;
        $display("FAIL rand_hit_pulse move=%0d act=%0d exp=%0d", i, hp, ehp);
      end
    end
    chk("rand_hit_mismatches", nbad, 0);
    sweep("rand_map");
    chk_count("rand_count");
    chk("rand_hit_sticky", int'(hit), mdl_hit);

    wait_ready();
    upd_valid = 1'b1;
    upd_grow  = 1'b1;
    upd_headx = 5'd10;
    upd_heady = 5'd10;
    tick();
    upd_valid = 1'b0;
    qry_x = 5'd10;
    qry_y = 5'd10;
    qry_en = 1'b1;
    tick();
    qry_en = 1'b0;
    chk("prewrite_done", int'(upd_done), 1);
    chk("prewrite_qry", int'(qry_occ), 0);
    mdl_move(1'b1, 10, 10, 0, 0, ehp);
    query(10, 10, occ);
    chk("postwrite_qry", occ, 1);

    begin
      bit gs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int acc [6];
      int dn  [6];
      int ehps [6];
      int k  = 0;
      int kd = 0;
      int cyc = 0;
      bit prev_ready;
      wait_ready();
      upd_valid = 1'b1;
      upd_grow  = gs[0];
      upd_headx = 5'd0;
      upd_heady = 5'd1;
      upd_tailx = 5'd1;
      upd_taily = 5'd2;
      qry_en = 1'b1;
      qry_x = 5'd0;
      qry_y = 5'd0;
      prev_ready = upd_ready;
      while (kd < 6 && cyc < 100) begin
        tick();
        cyc++;
        if (prev_ready && upd_valid) begin
          acc[k] = cyc;
          mdl_move(gs[k], 2 * k, 1, 2 * k + 1, 2, ehps[k]);
          k++;
          if (k < 6) begin
            upd_grow  = gs[k];
            upd_headx = HW'(2 * k);
            upd_tailx = HW'(2 * k + 1);
          end else begin
            upd_valid = 1'b0;
          end
        end
        if (upd_done && kd < k) begin
          dn[kd] = cyc;
          chk($sformatf("b2b%0d_latency", kd), dn[kd] - acc[kd], gs[kd] ? 1 : 2);
          if (kd > 0) chk($sformatf("b2b%0d_spacing", kd), dn[kd] - dn[kd-1], gs[kd] ? 2 : 3);
          chk($sformatf("b2b%0d_hit_pulse", kd), int'(hit_pulse), ehps[kd]);
          kd++;
        end
        prev_ready = upd_ready;
      end
      upd_valid = 1'b0;
      qry_en = 1'b0;
      chk("b2b_done_count", kd, 6);
    end
    chk("hit_still_set", int'(hit), 1);
    sweep("b2b_map");

    wait_ready();
    upd_valid = 1'b1;
    upd_grow  = 1'b0;
    upd_headx = 5'd6;
    upd_heady = 5'd6;
    upd_tailx = 5'd10;
    upd_taily = 5'd10;
    tick();
    do_reset();
    chk("post_rst_hit", int'(hit), 0);
    sweep("post_rst_map");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
